// File: rtl/sram_1rw1r_param_pkg.sv
// Shared types and helpers for the parametrised 1RW+1R SRAM wrapper:
// clear-sequencer state encoding, read-latency legality check and the
// lane-merge function used by both the array write path and the bypass path.
package sram_pkg;

    // Widest word the shared lane-merge helper handles.
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_IDX_W      = 8;

    typedef logic [MAX_DATA_WIDTH-1:0] wide_word_t;
    typedef logic [MAX_DATA_WIDTH-1:0] wide_mask_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Only one- and two-cycle registered read paths are implemented.
    function automatic bit read_latency_ok(input int unsigned lat);
        return (lat == 32'd1) || (lat == 32'd2);
    endfunction

    // Per-lane select: lanes whose mask bit is set take new_w, the rest keep old_w.
    // Callers zero-extend into the wide types and truncate the result back.
    function automatic wide_word_t merge_lanes(input wide_word_t  old_w,
                                               input wide_word_t  new_w,
                                               input wide_mask_t  mask,
                                               input int unsigned lane_bits);
        wide_word_t           res;
        logic [MAX_IDX_W-1:0] bit_idx;
        logic [MAX_IDX_W-1:0] lane_idx;
        res = old_w;
        for (int b = 0; b < MAX_DATA_WIDTH; b++) begin
            bit_idx  = MAX_IDX_W'(b);
            lane_idx = MAX_IDX_W'(32'(b) / lane_bits);
            if (mask[lane_idx] == 1'b1) begin
                res[bit_idx] = new_w[bit_idx];
            end else begin
                res[bit_idx] = old_w[bit_idx];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_1rw1r_param_if.sv
// Request/response bundle between the core's memory ports and the SRAM wrapper.
interface sram_1rw1r_param_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_WMASKS = 4
);
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  rvalid0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  rvalid1;
    logic                  clr_req;
    logic                  busy;
    logic                  clr_done;
    logic                  collision;
    logic [15:0]           collision_cnt;

    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1, clr_req,
        input  dout0, rvalid0, dout1, rvalid1, busy, clr_done, collision, collision_cnt
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1, clr_req,
        output dout0, rvalid0, dout1, rvalid1, busy, clr_done, collision, collision_cnt
    );
endinterface

// File: rtl/sram_1rw1r_param_array.sv
// Plain storage array: one masked synchronous write port, two synchronous
// read ports. No reset, so it can be replaced by the hard macro. A read and a
// write to the same word on the same edge return the old word.
module sram_array_1w2r
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned WMASK_SIZE = 8
) (
    input  logic                               clk_i,
    input  logic                               we_i,
    input  logic [ADDR_WIDTH-1:0]              waddr_i,
    input  logic [DATA_WIDTH-1:0]              wdata_i,
    input  logic [DATA_WIDTH/WMASK_SIZE-1:0]   wmask_i,
    input  logic                               re0_i,
    input  logic [ADDR_WIDTH-1:0]              raddr0_i,
    output logic [DATA_WIDTH-1:0]              rdata0_o,
    input  logic                               re1_i,
    input  logic [ADDR_WIDTH-1:0]              raddr1_i,
    output logic [DATA_WIDTH-1:0]              rdata1_o
);
    localparam int unsigned RAM_DEPTH = 32'd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    // Masked write: untouched lanes keep their stored value.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= DATA_WIDTH'(merge_lanes(MAX_DATA_WIDTH'(mem_q[waddr_i]),
                                                      MAX_DATA_WIDTH'(wdata_i),
                                                      MAX_DATA_WIDTH'(wmask_i),
                                                      WMASK_SIZE));
        end
    end

    // Port 0 read register; holds its value when not reading.
    always_ff @(posedge clk_i) begin
        if (re0_i) begin
            rdata0_q <= mem_q[raddr0_i];
        end
    end

    // Port 1 read register; holds its value when not reading.
    always_ff @(posedge clk_i) begin
        if (re1_i) begin
            rdata1_q <= mem_q[raddr1_i];
        end
    end

    assign rdata0_o = rdata0_q;
    assign rdata1_o = rdata1_q;
endmodule

// File: rtl/sram_1rw1r_param.sv
// 1RW+1R SRAM wrapper: request decode, registered read pipeline (1 or 2
// cycles), port-1 write-through bypass on collision, saturating collision
// counter and a hardware clear sequencer that zeroes the array one word per cycle.
module sram_1rw1r_param
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned WMASK_SIZE   = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          BYPASS       = 1'b1
) (
    input  logic               clk0,
    input  logic               rstb0,
    sram_1rw1r_param_if.slave  bus
);
    localparam int unsigned           NUM_WMASKS = DATA_WIDTH / WMASK_SIZE;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST   = {ADDR_WIDTH{1'b1}};

    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("sram_1rw1r_param: READ_LATENCY must be 1 or 2");
    end
    if ((NUM_WMASKS * WMASK_SIZE != DATA_WIDTH) || (DATA_WIDTH > MAX_DATA_WIDTH)) begin : g_bad_width
        $error("sram_1rw1r_param: WMASK_SIZE must divide DATA_WIDTH, DATA_WIDTH <= 256");
    end

    clr_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    clr_done_q, clr_done_d;
    logic                    busy_s;

    logic                    rd0_req_s, wr0_req_s, rd1_req_s, col_s;

    logic                    arr_we_s;
    logic [ADDR_WIDTH-1:0]   arr_waddr_s;
    logic [DATA_WIDTH-1:0]   arr_wdata_s;
    logic [NUM_WMASKS-1:0]   arr_wmask_s;
    logic [DATA_WIDTH-1:0]   arr_rdata0_s, arr_rdata1_s;

    logic                    s1_v0_q, s1_v1_q, s1_col_q;
    logic [DATA_WIDTH-1:0]   s1_din_q;
    logic [NUM_WMASKS-1:0]   s1_mask_q;
    logic [DATA_WIDTH-1:0]   s1_dout1_s;

    logic                    out_v0_s, out_v1_s;
    logic [DATA_WIDTH-1:0]   out_d0_s, out_d1_s;

    logic [DATA_WIDTH-1:0]   dout0_q, dout1_q;
    logic                    rvalid0_q, rvalid1_q;
    logic                    collision_q;
    logic [15:0]             collision_cnt_q;

    // Request acceptance: both ports are ignored while the clear sequence owns the array.
    always_comb begin
        busy_s    = (state_q == CLEAR);
        rd0_req_s = 1'b0;
        wr0_req_s = 1'b0;
        rd1_req_s = 1'b0;
        if (!busy_s) begin
            rd0_req_s = (bus.csb0 == 1'b0) && (bus.web0 == 1'b1);
            wr0_req_s = (bus.csb0 == 1'b0) && (bus.web0 == 1'b0);
            rd1_req_s = (bus.csb1 == 1'b0);
        end else begin
            rd0_req_s = 1'b0;
            wr0_req_s = 1'b0;
            rd1_req_s = 1'b0;
        end
        col_s = wr0_req_s && rd1_req_s && (bus.addr0 == bus.addr1);
    end

    // Array write port: the clear sequencer wins; port 0 is blocked while busy anyway.
    always_comb begin
        arr_we_s    = wr0_req_s;
        arr_waddr_s = bus.addr0;
        arr_wdata_s = bus.din0;
        arr_wmask_s = bus.wmask0;
        if (state_q == CLEAR) begin
            arr_we_s    = 1'b1;
            arr_waddr_s = ptr_q;
            arr_wdata_s = {DATA_WIDTH{1'b0}};
            arr_wmask_s = {NUM_WMASKS{1'b1}};
        end else begin
            arr_we_s    = wr0_req_s;
            arr_waddr_s = bus.addr0;
            arr_wdata_s = bus.din0;
            arr_wmask_s = bus.wmask0;
        end
    end

    sram_array_1w2r #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WMASK_SIZE (WMASK_SIZE)
    ) u_array (
        .clk_i    (clk0),
        .we_i     (arr_we_s),
        .waddr_i  (arr_waddr_s),
        .wdata_i  (arr_wdata_s),
        .wmask_i  (arr_wmask_s),
        .re0_i    (rd0_req_s),
        .raddr0_i (bus.addr0),
        .rdata0_o (arr_rdata0_s),
        .re1_i    (rd1_req_s),
        .raddr1_i (bus.addr1),
        .rdata1_o (arr_rdata1_s)
    );

    // First pipeline stage: valid bits alongside the array read, plus the colliding write for bypass.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            s1_v0_q   <= 1'b0;
            s1_v1_q   <= 1'b0;
            s1_col_q  <= 1'b0;
            s1_din_q  <= {DATA_WIDTH{1'b0}};
            s1_mask_q <= {NUM_WMASKS{1'b0}};
        end else begin
            s1_v0_q  <= rd0_req_s;
            s1_v1_q  <= rd1_req_s;
            s1_col_q <= col_s;
            if (col_s) begin
                s1_din_q  <= bus.din0;
                s1_mask_q <= bus.wmask0;
            end
        end
    end

    // Port-1 bypass: the array returned the pre-write word, overlay the written lanes.
    always_comb begin
        s1_dout1_s = arr_rdata1_s;
        if ((BYPASS == 1'b1) && s1_col_q) begin
            s1_dout1_s = DATA_WIDTH'(merge_lanes(MAX_DATA_WIDTH'(arr_rdata1_s),
                                                 MAX_DATA_WIDTH'(s1_din_q),
                                                 MAX_DATA_WIDTH'(s1_mask_q),
                                                 WMASK_SIZE));
        end else begin
            s1_dout1_s = arr_rdata1_s;
        end
    end

    if (READ_LATENCY == 32'd2) begin : g_lat2
        logic                  s2_v0_q, s2_v1_q;
        logic [DATA_WIDTH-1:0] s2_d0_q, s2_d1_q;

        // Extra register stage for the two-cycle read path.
        always_ff @(posedge clk0 or negedge rstb0) begin
            if (!rstb0) begin
                s2_v0_q <= 1'b0;
                s2_v1_q <= 1'b0;
                s2_d0_q <= {DATA_WIDTH{1'b0}};
                s2_d1_q <= {DATA_WIDTH{1'b0}};
            end else begin
                s2_v0_q <= s1_v0_q;
                s2_v1_q <= s1_v1_q;
                if (s1_v0_q) begin
                    s2_d0_q <= arr_rdata0_s;
                end
                if (s1_v1_q) begin
                    s2_d1_q <= s1_dout1_s;
                end
            end
        end

        assign out_v0_s = s2_v0_q;
        assign out_v1_s = s2_v1_q;
        assign out_d0_s = s2_d0_q;
        assign out_d1_s = s2_d1_q;
    end else begin : g_lat1
        assign out_v0_s = s1_v0_q;
        assign out_v1_s = s1_v1_q;
        assign out_d0_s = arr_rdata0_s;
        assign out_d1_s = s1_dout1_s;
    end

    // Output registers: data only changes on a completed read, so it never shows X.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            dout0_q   <= {DATA_WIDTH{1'b0}};
            dout1_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            rvalid0_q <= out_v0_s;
            rvalid1_q <= out_v1_s;
            if (out_v0_s) begin
                dout0_q <= out_d0_s;
            end
            if (out_v1_s) begin
                dout1_q <= out_d1_s;
            end
        end
    end

    // Collision strobe and saturating counter.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            collision_q     <= 1'b0;
            collision_cnt_q <= 16'h0000;
        end else begin
            collision_q <= col_s;
            if (col_s && (collision_cnt_q != 16'hFFFF)) begin
                collision_cnt_q <= collision_cnt_q + 16'h0001;
            end
        end
    end

    // Clear sequencer next state: walk ptr over every word, flag completion on the last one.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clr_req == 1'b1) begin
                    state_d = CLEAR;
                    ptr_d   = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_d = IDLE;
                    ptr_d   = ptr_q;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + ADDR_WIDTH'(1'b1);
                if (ptr_q == PTR_LAST) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end else begin
                    state_d    = CLEAR;
                    clr_done_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                ptr_d      = {ADDR_WIDTH{1'b0}};
                clr_done_d = 1'b0;
            end
        endcase
    end

    // Clear sequencer state registers.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            state_q    <= IDLE;
            ptr_q      <= {ADDR_WIDTH{1'b0}};
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign bus.dout0         = dout0_q;
    assign bus.rvalid0       = rvalid0_q;
    assign bus.dout1         = dout1_q;
    assign bus.rvalid1       = rvalid1_q;
    assign bus.busy          = (state_q == CLEAR);
    assign bus.clr_done      = clr_done_q;
    assign bus.collision     = collision_q;
    assign bus.collision_cnt = collision_cnt_q;
endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Directed bench for sram_1rw1r_param. Three instances share one stimulus:
// A = latency 1 / bypass, B = latency 1 / no bypass, C = latency 2 / bypass.
module tb_sram_1rw1r_param;

    logic        clk0 = 1'b0;
    logic        rstb0;
    logic        csb0, web0, csb1, clr_req;
    logic [3:0]  wmask0;
    logic [7:0]  addr0, addr1;
    logic [31:0] din0;

    int n_err = 0;
    int n_chk = 0;
    int busy_cycles, done_cnt, rv_cnt, bad, k;

    sram_1rw1r_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_WMASKS(4)) if_a ();
    sram_1rw1r_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_WMASKS(4)) if_b ();
    sram_1rw1r_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_WMASKS(4)) if_c ();

    assign if_a.csb0 = csb0;   assign if_b.csb0 = csb0;   assign if_c.csb0 = csb0;
    assign if_a.web0 = web0;   assign if_b.web0 = web0;   assign if_c.web0 = web0;
    assign if_a.wmask0 = wmask0; assign if_b.wmask0 = wmask0; assign if_c.wmask0 = wmask0;
    assign if_a.addr0 = addr0; assign if_b.addr0 = addr0; assign if_c.addr0 = addr0;
    assign if_a.din0 = din0;   assign if_b.din0 = din0;   assign if_c.din0 = din0;
    assign if_a.csb1 = csb1;   assign if_b.csb1 = csb1;   assign if_c.csb1 = csb1;
    assign if_a.addr1 = addr1; assign if_b.addr1 = addr1; assign if_c.addr1 = addr1;
    assign if_a.clr_req = clr_req; assign if_b.clr_req = clr_req; assign if_c.clr_req = clr_req;

    sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_SIZE(8),
                       .READ_LATENCY(1), .BYPASS(1'b1))
        dut_a (.clk0(clk0), .rstb0(rstb0), .bus(if_a));
    sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_SIZE(8),
                       .READ_LATENCY(1), .BYPASS(1'b0))
        dut_b (.clk0(clk0), .rstb0(rstb0), .bus(if_b));
    sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_SIZE(8),
                       .READ_LATENCY(2), .BYPASS(1'b1))
        dut_c (.clk0(clk0), .rstb0(rstb0), .bus(if_c));

    // Free-running clock, 10 time units per cycle.
    always #5 clk0 = ~clk0;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (drive and sample point).
    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; clr_req = 1'b0; wmask0 = 4'h0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
        step();
        idle();
    endtask

    task automatic rd_both(input logic [7:0] a0, input logic [7:0] a1);
        csb0 = 1'b0; web0 = 1'b1; addr0 = a0; csb1 = 1'b0; addr1 = a1;
        step();
        idle();
        step();
    endtask

    initial begin
        rstb0 = 1'b0; idle(); addr0 = 8'h00; addr1 = 8'h00; din0 = 32'h0;
        repeat (3) step();

        // Reset state
        chk("rst_dout0", if_a.dout0, 32'h0);
        chk("rst_dout1", if_a.dout1, 32'h0);
        chk("rst_rvalid0", {31'h0, if_a.rvalid0}, 32'h0);
        chk("rst_rvalid1", {31'h0, if_a.rvalid1}, 32'h0);
        chk("rst_busy", {31'h0, if_a.busy}, 32'h0);
        chk("rst_clr_done", {31'h0, if_a.clr_done}, 32'h0);
        chk("rst_collision", {31'h0, if_a.collision}, 32'h0);
        chk("rst_coll_cnt", {16'h0, if_a.collision_cnt}, 32'h0);
        chk("rst_c_dout1", if_c.dout1, 32'h0);
        rstb0 = 1'b1;
        step();

        // Full write then port-0 read, latency 1 and 2
        wr(8'h05, 32'hDEADBEEF, 4'hF);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h05;
        step();
        idle();
        chk("t1_rv0_early", {31'h0, if_a.rvalid0}, 32'h0);
        step();
        chk("t1_rv0", {31'h0, if_a.rvalid0}, 32'h1);
        chk("t1_dout0", if_a.dout0, 32'hDEADBEEF);
        chk("t1_c_rv0_early", {31'h0, if_c.rvalid0}, 32'h0);
        step();
        chk("t1_rv0_one_cycle", {31'h0, if_a.rvalid0}, 32'h0);
        chk("t1_dout0_hold", if_a.dout0, 32'hDEADBEEF);
        chk("t1_c_rv0", {31'h0, if_c.rvalid0}, 32'h1);
        chk("t1_c_dout0", if_c.dout0, 32'hDEADBEEF);

        // Masked write, no-op write, read on both ports
        wr(8'h10, 32'h11223344, 4'hF);
        wr(8'h10, 32'hAABBCCDD, 4'b0101);
        wr(8'h10, 32'hFFFFFFFF, 4'h0);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h10; csb1 = 1'b0; addr1 = 8'h10;
        step();
        idle();
        chk("t2_noop_no_rv0", {31'h0, if_a.rvalid0}, 32'h0);
        step();
        chk("t2_dout0", if_a.dout0, 32'h11BB33DD);
        chk("t2_dout1", if_a.dout1, 32'h11BB33DD);
        chk("t2_rv1", {31'h0, if_a.rvalid1}, 32'h1);
        chk("t2_b_dout1", if_b.dout1, 32'h11BB33DD);

        // Same-address collision, bypass vs old data
        wr(8'h20, 32'h12345678, 4'hF);
        csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h20; din0 = 32'hFFFF0000; wmask0 = 4'hC;
        csb1 = 1'b0; addr1 = 8'h20;
        step();
        idle();
        chk("t3_collision", {31'h0, if_a.collision}, 32'h1);
        chk("t3_coll_cnt", {16'h0, if_a.collision_cnt}, 32'h1);
        chk("t3_b_coll_cnt", {16'h0, if_b.collision_cnt}, 32'h1);
        step();
        chk("t3_bypass_dout1", if_a.dout1, 32'hFFFF5678);
        chk("t3_bypass_rv1", {31'h0, if_a.rvalid1}, 32'h1);
        chk("t3_nobypass_dout1", if_b.dout1, 32'h12345678);
        chk("t3_collision_pulse", {31'h0, if_a.collision}, 32'h0);
        step();
        chk("t3_c_bypass_dout1", if_c.dout1, 32'hFFFF5678);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h20;
        step();
        idle();
        step();
        chk("t3_written_word", if_a.dout0, 32'hFFFF5678);
        chk("t3_b_written_word", if_b.dout0, 32'hFFFF5678);

        // Back-to-back port-1 reads; addr 0 is written on the edge just before it is read
        for (int i = 3; i >= 0; i--) begin
            wr(8'(i), 32'hC0DE0000 + 32'(i), 4'hF);
        end
        csb1 = 1'b0; addr1 = 8'h00;
        step();
        addr1 = 8'h01;
        step();
        chk("t4_a_rv1", {31'h0, if_a.rvalid1}, 32'h1);
        chk("t4_a_dout1", if_a.dout1, 32'hC0DE0000);
        chk("t4_c_rv1_early", {31'h0, if_c.rvalid1}, 32'h0);
        addr1 = 8'h02;
        step();
        chk("t4_c_rv1_0", {31'h0, if_c.rvalid1}, 32'h1);
        chk("t4_c_dout1_0", if_c.dout1, 32'hC0DE0000);
        addr1 = 8'h03;
        step();
        chk("t4_c_rv1_1", {31'h0, if_c.rvalid1}, 32'h1);
        chk("t4_c_dout1_1", if_c.dout1, 32'hC0DE0001);
        idle();
        step();
        chk("t4_c_rv1_2", {31'h0, if_c.rvalid1}, 32'h1);
        chk("t4_c_dout1_2", if_c.dout1, 32'hC0DE0002);
        step();
        chk("t4_c_rv1_3", {31'h0, if_c.rvalid1}, 32'h1);
        chk("t4_c_dout1_3", if_c.dout1, 32'hC0DE0003);
        step();
        chk("t4_c_rv1_end", {31'h0, if_c.rvalid1}, 32'h0);

        // Fill, clear with traffic during busy
        for (int i = 0; i < 256; i++) begin
            wr(8'(i), 32'hA5000000 | 32'(i), 4'hF);
        end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        busy_cycles = 0; done_cnt = 0; rv_cnt = 0; k = 0;
        while ((if_a.busy === 1'b1) && (k < 400)) begin
            busy_cycles++;
            if (if_a.clr_done === 1'b1) done_cnt++;
            if ((if_a.rvalid0 === 1'b1) || (if_a.rvalid1 === 1'b1)) rv_cnt++;
            csb0 = 1'b0; web0 = 1'b0; addr0 = 8'(k); din0 = 32'hFFFFFFFF; wmask0 = 4'hF;
            csb1 = 1'b0; addr1 = 8'(k);
            clr_req = (k == 10);
            k++;
            step();
        end
        idle();
        chk("t5_busy_cycles", 32'(busy_cycles), 32'd256);
        chk("t5_clr_done_at_end", {31'h0, if_a.clr_done}, 32'h1);
        if (if_a.clr_done === 1'b1) done_cnt++;
        for (int i = 0; i < 4; i++) begin
            step();
            if (if_a.clr_done === 1'b1) done_cnt++;
            if ((if_a.rvalid0 === 1'b1) || (if_a.rvalid1 === 1'b1)) rv_cnt++;
        end
        chk("t5_clr_done_once", 32'(done_cnt), 32'd1);
        chk("t5_no_rvalid_busy", 32'(rv_cnt), 32'd0);
        chk("t5_idle_after", {31'h0, if_a.busy}, 32'h0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            rd_both(8'(i), 8'(255 - i));
            if (!((if_a.rvalid0 === 1'b1) && (if_a.dout0 === 32'h0) &&
                  (if_a.rvalid1 === 1'b1) && (if_a.dout1 === 32'h0))) bad++;
        end
        chk("t5_all_zero", 32'(bad), 32'd0);

        // Reset in the middle of a clear
        for (int i = 0; i < 256; i++) begin
            wr(8'(i), 32'hA5000000 | 32'(i), 4'hF);
        end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (100) step();
        chk("t6_busy_mid", {31'h0, if_a.busy}, 32'h1);
        rstb0 = 1'b0;
        #1;
        chk("t6_busy_reset", {31'h0, if_a.busy}, 32'h0);
        chk("t6_dout0_reset", if_a.dout0, 32'h0);
        chk("t6_dout1_reset", if_a.dout1, 32'h0);
        chk("t6_cnt_reset", {16'h0, if_a.collision_cnt}, 32'h0);
        chk("t6_clr_done_reset", {31'h0, if_a.clr_done}, 32'h0);
        step();
        rstb0 = 1'b1;
        step();
        chk("t6_stays_idle", {31'h0, if_a.busy}, 32'h0);
        rd_both(8'd99, 8'd100);
        chk("t6_word99_cleared", if_a.dout0, 32'h0);
        chk("t6_word100_kept", if_a.dout1, 32'hA5000064);
        rd_both(8'd0, 8'd255);
        chk("t6_word0_cleared", if_a.dout0, 32'h0);
        chk("t6_word255_kept", if_a.dout1, 32'hA50000FF);
        chk("t6_no_clr_done", {31'h0, if_a.clr_done}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
